// File: rtl/axil_mm2s.sv
// Generic FIFO: registered count, head read straight from storage.
// Latency: a push is visible at the head one cycle later.
// Backpressure: the caller guarantees space; a push while full without a pop is illegal.
module axil_mm2s_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_vld,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop_rdy,
   output logic [W-1:0]             head_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          pop;

   assign pop      = pop_rdy && (count != '0);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + 1'b1;
         if (pop)      rd_ptr <= rd_ptr + 1'b1;
         case ({push_vld, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_vld) mem[wr_ptr] <= push_dat;
   end

   // Credit accounting upstream makes overflow unreachable.
   assert property (@(posedge clk) disable iff (!rst_n) !(push_vld && !pop && count == FULL));
endmodule

// Reads cfg_len words from base upward over AXI-lite and streams them out with last.
// Latency: first address the cycle after start; response to out_valid is 1 cycle.
// Backpressure: out_ready stalls are absorbed by the FIFO; address issue is credit-limited.
module axil_mm2s #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   input  logic                  cfg_start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state;
   logic [LEN_WIDTH-1:0]   len_q, ar_idx, out_idx, inflight, ar_idx_nxt;
   logic [LEN_WIDTH:0]     credit_use;
   logic [CW-1:0]          fifo_cnt;
   logic [DATA_WIDTH-1:0]  head_dat;
   logic                   ar_acc, r_acc, pop_acc, ar_more;

   assign ar_acc    = m_arvalid && m_arready;
   assign r_acc     = m_rvalid && m_rready;
   assign pop_acc   = out_valid && out_ready;
   assign m_rready  = (state == RUN);
   assign out_valid = (fifo_cnt != '0);
   assign out_data  = out_valid ? head_dat : '0;
   assign out_last  = out_valid && (out_idx == len_q - 1'b1);

   // The address being accepted this cycle already holds a FIFO slot.
   assign ar_idx_nxt = ar_idx + LEN_WIDTH'(ar_acc);
   assign credit_use = (LEN_WIDTH+1)'(fifo_cnt) + (LEN_WIDTH+1)'(inflight) + (LEN_WIDTH+1)'(ar_acc);
   assign ar_more    = (ar_idx_nxt < len_q) && (credit_use < (LEN_WIDTH+1)'(FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         m_arvalid <= 1'b0;
         m_araddr  <= '0;
         len_q     <= '0;
         ar_idx    <= '0;
         out_idx   <= '0;
         inflight  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_start) begin
                  len_q    <= cfg_len;
                  m_araddr <= cfg_base_addr;
                  ar_idx   <= '0;
                  out_idx  <= '0;
                  inflight <= '0;
                  busy     <= 1'b1;
                  if (cfg_len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= RUN;
                     m_arvalid <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (!m_arvalid || m_arready) m_arvalid <= ar_more;
               if (ar_acc) begin
                  ar_idx   <= ar_idx_nxt;
                  m_araddr <= m_araddr + STRIDE;
               end
               case ({ar_acc, r_acc})
                  2'b10:   inflight <= inflight + 1'b1;
                  2'b01:   inflight <= inflight - 1'b1;
                  default: inflight <= inflight;
               endcase
               if (pop_acc) out_idx <= out_idx + 1'b1;
               if (pop_acc && out_last) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  m_arvalid <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   axil_mm2s_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (r_acc),
      .push_dat (m_rdata),
      .pop_rdy  (out_ready),
      .head_dat (head_dat),
      .count    (fifo_cnt)
   );
endmodule

// File: tb/tb_axil_mm2s.sv
// Randomized bench for axil_mm2s: AXI-lite memory slave with random latency,
// random stream sink, and a reference sequence built from base/len arithmetic.
module tb_axil_mm2s;
   localparam int DW = 32, AW = 16, LW = 16, DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] cfg_base_addr;
   logic [LW-1:0] cfg_len;
   logic          cfg_start;
   logic          busy, done;
   logic [AW-1:0] m_araddr;
   logic          m_arvalid, m_arready;
   logic [DW-1:0] m_rdata;
   logic          m_rvalid, m_rready;
   logic [DW-1:0] out_data;
   logic          out_valid, out_ready, out_last;

   always #5 clk = ~clk;

   axil_mm2s #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len), .cfg_start(cfg_start),
      .busy(busy), .done(done),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
   );

   typedef struct { logic [DW-1:0] d; int t; } rsp_t;
   rsp_t rq[$];

   int nvec = 0, nerr = 0, cyc = 0;
   int ar_pct = 100, out_pct = 100, max_lat = 1;
   logic [AW-1:0] x_base;
   int x_len, n_ar, n_out, n_done;
   logic [15:0] salt;
   bit exp_busy, last_hs_prev, start_prev, ar_stall, out_stall, out_stall_last;
   logic [AW-1:0] ar_stall_addr;
   logic [DW-1:0] out_stall_dat;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [AW-1:0] elem_addr(input int i);
      return AW'(int'(x_base) + i * (DW / 8));
   endfunction

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {salt, a};
   endfunction

   // One clock: check what is visible now, account for handshakes at the coming edge, then drive.
   task automatic cycle();
      bit hs_last, st_now, nb;
      rsp_t r;
      if (ar_stall) begin
         chk("ar_hold_vld", m_arvalid, 1);
         chk("ar_hold_addr", m_araddr, ar_stall_addr);
      end
      if (out_stall) begin
         chk("out_hold_dat", out_data, out_stall_dat);
         chk("out_hold_last", out_last, out_stall_last);
      end
      chk("busy", busy, exp_busy);
      if (done) begin
         n_done++;
         chk("done_timing", last_hs_prev || (start_prev && x_len == 0), 1);
         chk("done_beats", n_out, x_len);
      end
      hs_last = 0;
      if (m_arvalid && m_arready) begin
         chk("ar_in_range", n_ar < x_len, 1);
         chk("araddr", m_araddr, elem_addr(n_ar));
         r.d = mem_word(m_araddr);
         r.t = cyc + $urandom_range(max_lat, 1);
         rq.push_back(r);
         n_ar++;
         chk("credit", (n_ar - n_out) <= DEPTH, 1);
      end
      if (m_rvalid && m_rready) void'(rq.pop_front());
      if (out_valid && out_ready) begin
         chk("out_in_range", n_out < x_len, 1);
         chk("out_data", out_data, mem_word(elem_addr(n_out)));
         chk("out_last", out_last, n_out == x_len - 1);
         hs_last = out_last;
         n_out++;
      end
      ar_stall       = m_arvalid && !m_arready;
      ar_stall_addr  = m_araddr;
      out_stall      = out_valid && !out_ready;
      out_stall_dat  = out_data;
      out_stall_last = out_last;
      st_now = cfg_start && !exp_busy;
      nb = exp_busy;
      if (done) nb = 0;
      if (st_now) nb = 1;

      @(posedge clk); #1;
      cyc++;
      exp_busy     = nb;
      last_hs_prev = hs_last;
      start_prev   = st_now;
      m_arready = ($urandom_range(99, 0) < ar_pct);
      out_ready = ($urandom_range(99, 0) < out_pct);
      if (rq.size() > 0 && rq[0].t <= cyc) begin
         m_rvalid = 1'b1;
         m_rdata  = rq[0].d;
      end else begin
         m_rvalid = 1'b0;
         m_rdata  = '0;
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0; cfg_start = 1'b0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; out_ready = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_arvalid", m_arvalid, 0);
      chk("rst_rready", m_rready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_araddr", m_araddr, 0);
      chk("rst_out_data", out_data, 0);
      rst_n = 1'b1;
      rq.delete();
      exp_busy = 0; last_hs_prev = 0; start_prev = 0; ar_stall = 0; out_stall = 0;
   endtask

   task automatic start_xfer(input logic [AW-1:0] base, input int len, input logic [15:0] s);
      x_base = base; x_len = len; salt = s; n_ar = 0; n_out = 0;
      cfg_base_addr = base; cfg_len = LW'(len); cfg_start = 1'b1;
      cycle();
      cfg_start = 1'b0;
      cfg_base_addr = AW'($urandom);
      cfg_len = LW'($urandom);
   endtask

   task automatic wait_done(input bit hazard);
      int d0 = n_done;
      for (int k = 0; k < 4000 && n_done == d0; k++) begin
         if (hazard && k == 5) begin
            cfg_start = 1'b1; cfg_base_addr = 16'hBEE0; cfg_len = 3;
         end
         cycle();
         cfg_start = 1'b0;
      end
      chk("done_count", n_done - d0, 1);
      chk("beats_total", n_out, x_len);
      chk("addrs_total", n_ar, x_len);
      cycle();
   endtask

   initial begin
      int d0;
      cfg_base_addr = '0; cfg_len = '0; cfg_start = 1'b0; n_done = 0;
      x_len = 0; n_ar = 0; n_out = 0; salt = 0; x_base = 0;
      do_reset(3);
      repeat (2) cycle();

      // basic: memory returns its own address
      ar_pct = 100; out_pct = 100; max_lat = 1;
      start_xfer(16'h0100, 4, 16'h0000);
      wait_done(0);

      // zero length
      start_xfer(16'h0040, 0, 16'h1111);
      chk("zero_arvalid", m_arvalid, 0);
      chk("zero_out_valid", out_valid, 0);
      wait_done(0);

      // backpressure fills exactly the FIFO depth
      ar_pct = 100; out_pct = 0; max_lat = 2;
      start_xfer(16'h0200, 20, 16'h2222);
      repeat (40) cycle();
      chk("bp_ar_count", n_ar, DEPTH);
      chk("bp_arvalid", m_arvalid, 0);
      out_pct = 100;
      wait_done(0);

      // random stalls on every channel
      ar_pct = 50; out_pct = 50; max_lat = 5;
      start_xfer(16'h1000, 37, 16'($urandom));
      wait_done(0);
      for (int i = 0; i < 4; i++) begin
         ar_pct = $urandom_range(90, 20); out_pct = $urandom_range(90, 20);
         start_xfer(AW'($urandom) & 16'hFFFC, $urandom_range(30, 1), 16'($urandom));
         wait_done(0);
      end

      // start pulse while running is ignored
      ar_pct = 70; out_pct = 70;
      start_xfer(16'h0300, 12, 16'h3333);
      wait_done(1);

      // reset after 3 of 10 beats, then a clean 2-beat transfer
      start_xfer(16'h0400, 10, 16'h4444);
      for (int k = 0; k < 500 && n_out < 3; k++) cycle();
      chk("mid_beats", n_out >= 3, 1);
      do_reset(1);
      d0 = n_done;
      repeat (5) cycle();
      chk("no_done_after_rst", n_done - d0, 0);
      start_xfer(16'h0500, 2, 16'h5555);
      wait_done(0);

      // address wrap at the top of the 16-bit space
      ar_pct = 100; out_pct = 100; max_lat = 1;
      start_xfer(16'hFFFC, 2, 16'h6666);
      wait_done(0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
